exec_ctrl: RTL

//  Execution controller: the issuing side of the ALU op circuits.
//  - Accepts 20-bit instruction words from fetch over a valid/ready handshake.
//  - Drives ALU opcode, mode and operands; captures result and flags.
//  - Writes results back to the register file; owns PC and the 13-bit status register.
//  - Executes jumps (JMP/JMPZ/JMPS/JMPZS), LSTAT, XSTAT and TRAP.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/exec_ctrl_decode.sv | 23 ++
 rtl/exec_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and status-bit positions for the execution controller.
package alu_pkg;

  localparam logic [4:0] OP_NOP      = 5'd0;
  localparam logic [4:0] OP_TRAP     = 5'd1;
  localparam logic [4:0] OP_JMP      = 5'd2;
  localparam logic [4:0] OP_JMPZ     = 5'd3;
  localparam logic [4:0] OP_JMPS     = 5'd4;
  localparam logic [4:0] OP_JMPZS    = 5'd5;
  localparam logic [4:0] OP_LSTAT    = 5'd6;
  localparam logic [4:0] OP_XSTAT    = 5'd7;
  localparam logic [4:0] OP_ALU_BASE = 5'd8;
  localparam logic [4:0] OP_ADD      = 5'd8;
  // Compare group (flags only, no writeback) sits just below SWAP.
  localparam logic [4:0] OP_CMP      = 5'd28;
  localparam logic [4:0] OP_CMPU     = 5'd29;
  localparam logic [4:0] OP_TST      = 5'd30;
  localparam logic [4:0] OP_SWAP     = 5'd31;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_TGT    = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_WB2    = 3'd5
  } state_t;

  localparam int SB_Z = 0;
  localparam int SB_S = 1;
  localparam int SB_C = 2;
  localparam int SB_T = 3;
  localparam int SB_M = 4;

endpackage

// File: rtl/exec_ctrl_decode.sv
// Pure combinational opcode classifier for the execution controller.
module exec_ctrl_decode
  import alu_pkg::*;
(
  input  logic [4:0] i_op,
  output logic       o_is_jump,
  output logic       o_is_cmp,
  output logic       o_is_swap,
  output logic       o_is_alu,
  output logic       o_is_trap,
  output logic       o_writes_rd
);

  always_comb begin
    o_is_jump   = (i_op >= OP_JMP) && (i_op <= OP_JMPZS);
    o_is_alu    = (i_op >= OP_ALU_BASE);
    o_is_cmp    = (i_op >= OP_CMP) && (i_op <= OP_TST);
    o_is_swap   = (i_op == OP_SWAP);
    o_is_trap   = (i_op == OP_TRAP);
    o_writes_rd = (o_is_alu && !o_is_cmp) || (i_op == OP_LSTAT) || (i_op == OP_XSTAT);
  end

endmodule

// File: rtl/exec_ctrl.sv
// Execution controller: fetch handshake, ALU issue, register writeback, PC and status.
// Build option EXEC_CTRL_TRAP_EN enables TRAP/epc handling; otherwise TRAP behaves as NOP.
module exec_ctrl
  import alu_pkg::*;
#(
  parameter int                DATA_W   = 20,
  parameter int                STAT_W   = 13,
  parameter int                RA_W     = 4,
  parameter logic [DATA_W-1:0] RESET_PC = 20'h00000
`ifdef EXEC_CTRL_TRAP_EN
  ,
  parameter logic [DATA_W-1:0] TRAP_VECTOR = 20'h00010
`endif
) (
  input  logic              clk,
  input  logic              rst,
  // A word transfers on a rising edge with instr_valid && instr_ready; ready never depends on valid.
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] instr,
  output logic [4:0]        alu_op,
  output logic              alu_mode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] alu_res_b,
  input  logic              alu_zero,
  input  logic              alu_sign,
  input  logic              alu_carry,
  output logic [RA_W-1:0]   rf_raddr_a,
  output logic [RA_W-1:0]   rf_raddr_b,
  input  logic [DATA_W-1:0] rf_rdata_a,
  input  logic [DATA_W-1:0] rf_rdata_b,
  output logic              rf_we,
  output logic [RA_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] pc,
  output logic [STAT_W-1:0] status,
  output logic [2:0]        dbg_state
);

  localparam logic [DATA_W-1:0] PC_ONE = DATA_W'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] r_res;
  logic [DATA_W-1:0] r_res_b;
  logic [4:0]        r_stat;
`ifdef EXEC_CTRL_TRAP_EN
  logic [DATA_W-1:0] r_epc;
`endif

  logic [4:0]        w_op;
  logic [RA_W-1:0]   w_rd;
  logic [RA_W-1:0]   w_rs;
  logic [DATA_W-1:0] w_stat_ext;
  logic              w_is_jump, w_is_cmp, w_is_swap, w_is_alu, w_is_trap, w_writes_rd;
  logic              w_take;
  logic              w_unused_bits;

  assign w_op       = r_instr[19:15];
  assign w_rd       = r_instr[13:10];
  assign w_rs       = r_instr[9:6];
  assign w_stat_ext = {{(DATA_W-5){1'b0}}, r_stat};

`ifdef EXEC_CTRL_TRAP_EN
  assign w_unused_bits = ^r_instr[5:0];
`else
  assign w_unused_bits = ^{r_instr[5:0], w_is_trap};
`endif

  exec_ctrl_decode u_decode (
    .i_op        (w_op),
    .o_is_jump   (w_is_jump),
    .o_is_cmp    (w_is_cmp),
    .o_is_swap   (w_is_swap),
    .o_is_alu    (w_is_alu),
    .o_is_trap   (w_is_trap),
    .o_writes_rd (w_writes_rd)
  );

  // Jump conditions look only at the registered flags, never the live ALU outputs.
  always_comb begin
    case (w_op)
      OP_JMP:   w_take = 1'b1;
      OP_JMPZ:  w_take = r_stat[SB_Z];
      OP_JMPS:  w_take = r_stat[SB_S];
      OP_JMPZS: w_take = r_stat[SB_Z] && r_stat[SB_S];
      default:  w_take = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FETCH:  if (instr_valid) w_state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (w_is_jump)        w_state_nxt = ST_TGT;
        else if (w_is_alu)    w_state_nxt = ST_EXEC;
        else if (w_writes_rd) w_state_nxt = ST_WB;
        else                  w_state_nxt = ST_FETCH;
      end
      ST_TGT:    if (instr_valid) w_state_nxt = ST_FETCH;
      ST_EXEC:   w_state_nxt = w_is_cmp ? ST_FETCH : ST_WB;
      ST_WB:     w_state_nxt = w_is_swap ? ST_WB2 : ST_FETCH;
      ST_WB2:    w_state_nxt = ST_FETCH;
      default:   w_state_nxt = ST_FETCH;
    endcase
  end

  always_comb begin
    instr_ready = (r_state == ST_FETCH) || (r_state == ST_TGT);
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    case (r_state)
      ST_WB: begin
        rf_we    = 1'b1;
        rf_waddr = w_rd;
        rf_wdata = r_res;
      end
      ST_WB2: begin
        rf_we    = 1'b1;
        rf_waddr = w_rs;
        rf_wdata = r_res_b;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_res   <= '0;
      r_res_b <= '0;
      r_stat  <= '0;
`ifdef EXEC_CTRL_TRAP_EN
      r_epc   <= '0;
`endif
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (instr_valid) begin
            r_instr <= instr;
            r_pc    <= r_pc + PC_ONE;
          end
        end
        ST_DECODE: begin
          if (w_op == OP_LSTAT)      r_res <= w_stat_ext;
          else if (w_op == OP_XSTAT) r_res <= r_stat[SB_T] ? (rf_rdata_a ^ w_stat_ext) : '0;
`ifdef EXEC_CTRL_TRAP_EN
          // First TRAP enters the handler; a TRAP inside the handler returns.
          if (w_is_trap) begin
            if (!r_stat[SB_T]) begin
              r_stat[SB_T] <= 1'b1;
              r_epc        <= r_pc;
              r_pc         <= TRAP_VECTOR;
            end else begin
              r_stat[SB_T] <= 1'b0;
              r_pc         <= r_epc;
            end
          end
`endif
        end
        ST_TGT: begin
          if (instr_valid) r_pc <= w_take ? instr : r_pc + PC_ONE;
        end
        ST_EXEC: begin
          r_res        <= alu_res;
          r_res_b      <= alu_res_b;
          r_stat[SB_Z] <= alu_zero;
          r_stat[SB_S] <= alu_sign;
          r_stat[SB_C] <= alu_carry;
          r_stat[SB_M] <= alu_mode;
        end
        default: ;
      endcase
    end
  end

  assign alu_op     = w_op;
  assign alu_mode   = r_instr[14];
  assign alu_a      = rf_rdata_a;
  assign alu_b      = rf_rdata_b;
  assign rf_raddr_a = w_rd;
  assign rf_raddr_b = w_rs;
  assign pc         = r_pc;
  assign status     = {{(STAT_W-5){1'b0}}, r_stat};
  assign dbg_state  = r_state;

endmodule
